// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// prefetch depth, FSM state encodings and the idle instruction word.
package inst_fetch_unit_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_INST_W = 32;
    localparam int FIFO_DEPTH = 2;

    // Fetch FSM encodings
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Value shown on ir when nothing is buffered
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Two-entry prefetch buffer holding {instruction, fetch address} pairs.
// Flush empties it in one cycle; head is always visible on data_o.
module fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int WIDTH = DEF_INST_W + DEF_ADDR_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;

    // Storage, pointers and occupancy; flush wins over any push/pop that cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 2'd1;
            end else if (!push_i && pop_i) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The issue logic upstream must never let a push land on a full buffer
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && !flush_i && count_q == 2'd2));

    // Decode only pops when ir_valid, so an empty pop means a broken handshake
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && !flush_i && count_q == 2'd0));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction memory
// read in flight, buffers returned words in a 2-entry prefetch FIFO and hands
// them to decode over valid/ready. Redirect flushes everything fetched so far;
// halt only stops new reads from being issued.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              ir_valid,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam int ENTRY_W = INST_W + ADDR_W;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   tag_q, tag_d;

    logic [ENTRY_W-1:0]  fifo_head;
    logic [1:0]          fifo_count;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                rsp_fire;
    logic                issue_slot;
    logic [2:0]          occupancy;
    logic                issue;

    assign fifo_empty = (fifo_count == 2'd0);

    // Decode never sees a valid head during a redirect, so no transfer can happen then
    assign ir_valid  = !fifo_empty && !redirect_valid;
    assign fifo_pop  = ir_valid && ir_ready;

    // A response only counts while WAIT; in FETCH it is stray, in DRAIN it is stale
    assign rsp_fire  = (state_q == ST_WAIT) && imem_rvalid;
    assign fifo_push = rsp_fire && !redirect_valid;

    // A new read may start when nothing is in flight, or the one in flight lands this cycle
    assign issue_slot = (state_q == ST_FETCH) || rsp_fire;

    // Buffer occupancy once this cycle's push and pop settle; counting the pop is
    // what lets a 1-cycle memory sustain one instruction per cycle
    assign occupancy = {1'b0, fifo_count} + {2'b00, fifo_push} - {2'b00, fifo_pop};

    assign issue = sys_rst_n && !halt && !redirect_valid && issue_slot &&
                   (occupancy < 3'(FIFO_DEPTH));

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    assign ir    = fifo_empty ? INST_W'(NOP_INST) : fifo_head[ENTRY_W-1:ADDR_W];
    assign ir_pc = fifo_empty ? '0 : fifo_head[ADDR_W-1:0];

    // Next FSM state, PC and in-flight address tag; redirect overrides everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (state_q == ST_FETCH || imem_rvalid) begin
                state_d = ST_FETCH;
            end else begin
                state_d = ST_DRAIN;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (issue) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = issue ? ST_WAIT : ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
            if (issue) begin
                pc_d  = pc_q + ADDR_W'(1);
                tag_d = pc_q;
            end
        end
    end

    // Fetch control registers; reset abandons any read in flight
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fetch_fifo (
        .clk_i   (clk),
        .rst_ni  (sys_rst_n),
        .push_i  (fifo_push),
        .data_i  ({imem_rdata, tag_q}),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a small instruction memory model
// of programmable latency. Outputs are sampled on the falling clock edge.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [3:0]  ir_pc;
    logic        ir_ready;
    logic        redirect_valid;
    logic [3:0]  redirect_pc;
    logic        halt;

    int assertCount = 0;
    int failCount   = 0;

    // Memory model state
    int         memLatency = 1;
    bit         memPending = 1'b0;
    int         memWait    = 0;
    logic [3:0] memAddr    = 4'd0;

    // Falling-edge snapshot of the cycle just completed
    logic        snapReq;
    logic [3:0]  snapAddr;
    logic        snapValid;
    logic [3:0]  snapPc;
    logic [31:0] snapIr;

    inst_fetch_unit dut (
        .clk            (clk),
        .sys_rst_n      (sys_rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_ready       (ir_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [3:0] a);
        return {16'hC0DE, 12'h000, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic hlt,
                                 input logic redir, input logic [3:0] rpc);
        ir_ready       = ready;
        halt           = hlt;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    // Snapshot outputs at the falling edge, then advance the memory model
    // just after the rising edge that the DUT used to sample the request
    task automatic stepCycle();
        @(negedge clk);
        snapReq   = imem_req;
        snapAddr  = imem_addr;
        snapValid = ir_valid;
        snapPc    = ir_pc;
        snapIr    = ir;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (snapReq && sys_rst_n) begin
            memPending = 1'b1;
            memAddr    = snapAddr;
            memWait    = memLatency;
        end
        if (memPending) begin
            memWait--;
            if (memWait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(memAddr);
                memPending  = 1'b0;
            end
        end
    endtask

    task automatic applyReset();
        sys_rst_n   = 1'b0;
        memPending  = 1'b0;
        imem_rvalid = 1'b0;
        stepCycle();
        stepCycle();
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        failCount++;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        int  reqs;
        bit  seen;
        int  at;
        logic [3:0]  firstPc;
        logic [31:0] firstIr;

        sys_rst_n   = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        #2;

        // Test 1: reset values, then streaming with a 1-cycle memory
        $display("[TB] test 1: reset and streaming");
        sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        checkOutput("rst_ir_pc", 32'(ir_pc), 32'd0);
        memLatency = 1;
        applyReset();
        for (int k = 0; k < 20; k++) begin
            stepCycle();
            if (k < 2) begin
                checkOutput("t1_startup_valid", 32'(snapValid), 32'd0);
            end else begin
                checkOutput("t1_valid", 32'(snapValid), 32'd1);
                checkOutput("t1_pc", 32'(snapPc), 32'((k - 2) % 16));
                checkOutput("t1_ir", snapIr, memWord(4'((k - 2) % 16)));
            end
        end

        // Test 2: decode stalled for 6 cycles, then released
        $display("[TB] test 2: backpressure");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        applyReset();
        reqs = 0;
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            reqs += 32'(snapReq);
            if (k >= 2) begin
                checkOutput("t2_stall_valid", 32'(snapValid), 32'd1);
                checkOutput("t2_stall_pc", 32'(snapPc), 32'd0);
                checkOutput("t2_stall_ir", snapIr, memWord(4'd0));
            end
        end
        checkOutput("t2_req_count", 32'(reqs), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            if (k == 0) begin
                checkOutput("t2_resume_req", 32'(snapReq), 32'd1);
                checkOutput("t2_resume_addr", 32'(snapAddr), 32'd2);
            end
            checkOutput("t2_release_valid", 32'(snapValid), 32'd1);
            checkOutput("t2_release_pc", 32'(snapPc), 32'(k));
        end

        // Test 3: redirect to 9 while a 3-cycle read is in flight
        $display("[TB] test 3: redirect with drain");
        memLatency = 3;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyReset();
        stepCycle();
        checkOutput("t3_issue_addr0", 32'(snapReq), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd9);
        stepCycle();
        checkOutput("t3_redirect_valid", 32'(snapValid), 32'd0);
        checkOutput("t3_redirect_req", 32'(snapReq), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        seen = 1'b0;
        at = -1;
        firstPc = 4'd0;
        firstIr = 32'd0;
        for (int k = 0; k < 20; k++) begin
            stepCycle();
            if (k < 2) begin
                checkOutput("t3_drain_req", 32'(snapReq), 32'd0);
            end
            if (k == 2) begin
                checkOutput("t3_refetch_req", 32'(snapReq), 32'd1);
                checkOutput("t3_refetch_addr", 32'(snapAddr), 32'd9);
            end
            if (!seen && snapValid) begin
                seen = 1'b1;
                firstPc = snapPc;
                firstIr = snapIr;
                at = k;
            end
        end
        checkOutput("t3_delivered", 32'(seen), 32'd1);
        checkOutput("t3_first_pc", 32'(firstPc), 32'd9);
        checkOutput("t3_first_ir", firstIr, memWord(4'd9));
        checkOutput("t3_first_cycle", 32'(at), 32'd6);

        // Test 4: redirect to 14 during streaming, address wraps
        $display("[TB] test 4: redirect and wrap");
        memLatency = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyReset();
        for (int k = 0; k < 4; k++) begin
            stepCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd14);
        stepCycle();
        checkOutput("t4_redirect_valid", 32'(snapValid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            if (k < 2) begin
                checkOutput("t4_refill_valid", 32'(snapValid), 32'd0);
            end else begin
                checkOutput("t4_wrap_valid", 32'(snapValid), 32'd1);
                checkOutput("t4_wrap_pc", 32'(snapPc), 32'((14 + k - 2) % 16));
            end
        end

        // Test 5: halt raised with one read in flight
        $display("[TB] test 5: halt");
        memLatency = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyReset();
        stepCycle();
        checkOutput("t5_issue_req", 32'(snapReq), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        reqs = 0;
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            reqs += 32'(snapReq);
            if (k == 1) begin
                checkOutput("t5_inflight_valid", 32'(snapValid), 32'd1);
                checkOutput("t5_inflight_pc", 32'(snapPc), 32'd0);
            end else if (k >= 2) begin
                checkOutput("t5_halted_valid", 32'(snapValid), 32'd0);
            end
        end
        checkOutput("t5_halted_reqs", 32'(reqs), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        stepCycle();
        checkOutput("t5_resume_req", 32'(snapReq), 32'd1);
        checkOutput("t5_resume_addr", 32'(snapAddr), 32'd1);
        seen = 1'b0;
        firstPc = 4'd0;
        for (int k = 0; k < 10; k++) begin
            stepCycle();
            if (!seen && snapValid) begin
                seen = 1'b1;
                firstPc = snapPc;
            end
        end
        checkOutput("t5_resume_delivered", 32'(seen), 32'd1);
        checkOutput("t5_resume_pc", 32'(firstPc), 32'd1);

        // Test 6: asynchronous reset with a buffered word and a read in flight
        $display("[TB] test 6: reset mid-operation");
        memLatency = 3;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        applyReset();
        for (int k = 0; k < 5; k++) begin
            stepCycle();
        end
        checkOutput("t6_pre_valid", 32'(snapValid), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("t6_async_req", 32'(imem_req), 32'd0);
        checkOutput("t6_async_addr", 32'(imem_addr), 32'd0);
        checkOutput("t6_async_valid", 32'(ir_valid), 32'd0);
        checkOutput("t6_async_ir", ir, 32'd0);
        checkOutput("t6_async_pc", 32'(ir_pc), 32'd0);
        memPending  = 1'b0;
        imem_rvalid = 1'b0;
        stepCycle();
        stepCycle();
        memLatency = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        sys_rst_n   = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            if (k == 0) begin
                checkOutput("t6_first_addr", 32'(snapAddr), 32'd0);
            end
            if (k < 2) begin
                checkOutput("t6_startup_valid", 32'(snapValid), 32'd0);
            end else begin
                checkOutput("t6_valid", 32'(snapValid), 32'd1);
                checkOutput("t6_pc", 32'(snapPc), 32'(k - 2));
                checkOutput("t6_ir", snapIr, memWord(4'(k - 2)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
